// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register for the RV32I pipeline.
// Owns the PC, talks to a wait-state imem, buffers one word across stalls and honours EX redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_add4,
    output logic [31:0] id_inst
);

    typedef enum logic {FETCH, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_pc_q, drop_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_add4_q, id_pc_add4_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic        req_int;
    logic        fetch_done;
    logic [31:0] redir_tgt;

    // A full holding buffer suppresses new requests; a DROP keeps the old request alive until it retires.
    assign req_int    = (state_q == DROP) || !buf_valid_q;
    assign fetch_done = req_int && imem_ready && (state_q == FETCH);
    assign redir_tgt  = {redirect_pc[31:2], 2'b00};

    assign imem_req   = req_int && !rst;
    assign imem_addr  = pc_q;
    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_pc_add4 = id_pc_add4_q;
    assign id_inst    = id_inst_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_pc_d    = drop_pc_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_pc_add4_d = id_pc_add4_q;
        id_inst_d    = id_inst_q;

        case (state_q)
            FETCH: begin
                if (redirect_en) begin
                    if (req_int && !imem_ready) begin
                        state_d   = DROP;
                        drop_pc_d = redir_tgt;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (fetch_done) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            DROP: begin
                if (redirect_en) begin
                    drop_pc_d = redir_tgt;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                    pc_d    = redirect_en ? redir_tgt : drop_pc_q;
                end
            end
            default: state_d = FETCH;
        endcase

        // The buffer only fills while stalled with an empty buffer, so a drain never races a completion.
        if (redirect_en) begin
            id_valid_d  = 1'b0;
            id_inst_d   = NOP_INST;
            buf_valid_d = 1'b0;
        end else if (stall_if) begin
            if (fetch_done) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = pc_q;
                buf_inst_d  = imem_rdata;
            end
        end else if (buf_valid_q) begin
            buf_valid_d  = 1'b0;
            id_valid_d   = 1'b1;
            id_pc_d      = buf_pc_q;
            id_pc_add4_d = buf_pc_q + 32'd4;
            id_inst_d    = buf_inst_q;
        end else if (fetch_done) begin
            id_valid_d   = 1'b1;
            id_pc_d      = pc_q;
            id_pc_add4_d = pc_q + 32'd4;
            id_inst_d    = imem_rdata;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drop_pc_q    <= RESET_PC;
            buf_valid_q  <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'd0;
            id_pc_add4_q <= 32'd0;
            id_inst_q    <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_pc_q    <= drop_pc_d;
            buf_valid_q  <= buf_valid_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_pc_add4_q <= id_pc_add4_d;
            id_inst_q    <= id_inst_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_pc_q   <= buf_pc_d;
        buf_inst_q <= buf_inst_d;
    end

endmodule
